// File: rtl/nrf_ce_pkg.sv
// Shared state encoding and default timing constants for the nRF2401 CE controller.
// The LOCK state exists only when NRF_CE_TX_TIMEOUT_EN is defined.
package nrf_ce_pkg;

    localparam int DEF_TX_PULSE_CYCLES = 500;
    localparam int DEF_GAP_CYCLES      = 250;
    localparam int DEF_SETTLE_CYCLES   = 6500;
    localparam int DEF_MAX_TX_CYCLES   = 200000;

`ifdef NRF_CE_TX_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2,
        ST_LOCK = 2'd3
    } ce_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } ce_state_e;
`endif

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/nrf2401_ce_ctrl.sv
// CE pin sequencer for the nRF2401: stretches TX bursts, enforces a CE-low gap and flags RX settling.
// Define NRF_CE_TX_TIMEOUT_EN to add the TX CE-high limit (LOCK state and timeout pulse).
module nrf2401_ce_ctrl
    import nrf_ce_pkg::*;
#(
    parameter int TX_PULSE_CYCLES = DEF_TX_PULSE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int MAX_TX_CYCLES   = DEF_MAX_TX_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_req,
    input  logic       mode_tx,
    output logic       ce_out,
    output logic       busy,
    output logic       rx_ready,
    output logic       tx_done,
    output logic       timeout,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = $clog2(max4(TX_PULSE_CYCLES, GAP_CYCLES,
                                       SETTLE_CYCLES, MAX_TX_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_THR = CNT_W'(SETTLE_CYCLES);
`ifdef NRF_CE_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAX_TX_LAST = CNT_W'(MAX_TX_CYCLES - 1);
`endif

    ce_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             mode_q, mode_d;
    logic             ce_out_q, ce_out_d;
    logic             tx_done_q, tx_done_d;
    logic             timeout_q, timeout_d;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // ce_req is a level request sampled every edge; mode_tx is only looked at on entry to HIGH.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        mode_d    = mode_q;
        tx_done_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ce_req) begin
                    state_d = ST_HIGH;
                    mode_d  = mode_tx;
                end
            end
            ST_HIGH: begin
`ifdef NRF_CE_TX_TIMEOUT_EN
                if (mode_q && (cnt_q == MAX_TX_LAST)) begin
                    state_d   = ST_LOCK;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else
`endif
                if (mode_q) begin
                    if (!ce_req && (cnt_q >= TX_LAST)) begin
                        state_d   = ST_GAP;
                        tx_done_d = 1'b1;
                        cnt_d     = '0;
                    end
                end else if (!ce_req) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    // A request still pending at gap end goes straight back to HIGH.
                    if (ce_req) begin
                        state_d = ST_HIGH;
                        mode_d  = mode_tx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef NRF_CE_TX_TIMEOUT_EN
            ST_LOCK: begin
                cnt_d = '0;
                if (!ce_req) state_d = ST_GAP;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        ce_out_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            ce_out_q  <= 1'b0;
            tx_done_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            ce_out_q  <= ce_out_d;
            tx_done_q <= tx_done_d;
            timeout_q <= timeout_d;
        end
    end

    assign ce_out    = ce_out_q;
    assign tx_done   = tx_done_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q != ST_IDLE);
    assign rx_ready  = (state_q == ST_HIGH) & ~mode_q & (cnt_q >= SETTLE_THR);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_nrf2401_ce_ctrl.sv
// Randomized bench for nrf2401_ce_ctrl: a burst-level model predicts each CE pulse and busy window.
// Honours NRF_CE_TX_TIMEOUT_EN so the same bench covers both builds.
module tb_nrf2401_ce_ctrl;

    localparam int TX_PULSE = 8;
    localparam int GAP      = 4;
    localparam int SETTLE   = 16;
    localparam int MAX_TX   = 32;
`ifdef NRF_CE_TX_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       ce_req;
    logic       mode_tx;
    logic       ce_out;
    logic       busy;
    logic       rx_ready;
    logic       tx_done;
    logic       timeout;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    // Pulse record: {high length, rx_ready first position (0 = never), rx_ready cycles}
    logic [23:0] exp_pulse_q[$];
    // Busy record: {busy length, pulses, tx_done pulses, timeout pulses}
    logic [19:0] exp_busy_q[$];

    nrf2401_ce_ctrl #(
        .TX_PULSE_CYCLES(TX_PULSE),
        .GAP_CYCLES     (GAP),
        .SETTLE_CYCLES  (SETTLE),
        .MAX_TX_CYCLES  (MAX_TX)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce_req   (ce_req),
        .mode_tx  (mode_tx),
        .ce_out   (ce_out),
        .busy     (busy),
        .rx_ready (rx_ready),
        .tx_done  (tx_done),
        .timeout  (timeout),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // An isolated burst with ce_req high for l cycles, starting from IDLE.
    task automatic push_model(input bit m, input int l);
        int hi, bl, rxf, rxc, done, tout;
        hi   = (m && l < TX_PULSE) ? TX_PULSE : l;
        bl   = hi + GAP;
        done = m ? 1 : 0;
        tout = 0;
        if (TOUT_EN && m && l >= MAX_TX) begin
            hi   = MAX_TX;
            done = 0;
            tout = 1;
            bl   = ((l > MAX_TX) ? l : MAX_TX + 1) + GAP;
        end
        rxf = (!m && l > SETTLE) ? SETTLE + 1 : 0;
        rxc = (!m && l > SETTLE) ? l - SETTLE : 0;
        exp_pulse_q.push_back({8'(hi), 8'(rxf), 8'(rxc)});
        exp_busy_q.push_back({8'(bl), 4'd1, 4'(done), 4'(tout)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit req, input bit m);
        @(posedge clk);
        #2;
        ce_req  = req;
        mode_tx = m;
    endtask

    task automatic run_txn(input bit m, input int l);
        int idle;
        push_model(m, l);
        cycle(1'b1, m);
        for (int i = 1; i < l; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        idle = 14 + $urandom_range(0, 6);
        for (int i = 0; i < idle; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int m_hi, m_rxf, m_rxc, m_bl, m_pulses, m_done, m_tout;
    logic prev_ce, prev_busy;
    logic [23:0] act_p, exp_p;
    logic [19:0] act_b, exp_b;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_hi = 0; m_rxf = 0; m_rxc = 0;
            m_bl = 0; m_pulses = 0; m_done = 0; m_tout = 0;
            prev_ce = 1'b0; prev_busy = 1'b0;
        end else begin
            if (busy) m_bl++;
            if (tx_done) m_done++;
            if (timeout) m_tout++;
            if (ce_out) m_hi++;
            if (rx_ready) begin
                m_rxc++;
                if (m_rxf == 0) m_rxf = m_hi;
            end
            if (prev_ce && !ce_out) begin
                m_pulses++;
                act_p = {8'(m_hi), 8'(m_rxf), 8'(m_rxc)};
                checks++;
                if (exp_pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: unexpected ce_out pulse hi=%0d rx_first=%0d rx_cnt=%0d",
                             m_hi, m_rxf, m_rxc);
                end else begin
                    exp_p = exp_pulse_q.pop_front();
                    if (act_p !== exp_p)begin
                        errors++;
                        $display("FAIL pulse: got hi=%0d rx_first=%0d rx_cnt=%0d expected hi=%0d rx_first=%0d rx_cnt=%0d",
                                 act_p[23:16], act_p[15:8], act_p[7:0], exp_p[23:16], exp_p[15:8], exp_p[7:0]);
                    end
                end
                m_hi = 0; m_rxf = 0; m_rxc = 0;
            end
            if (prev_busy && !busy) begin
                act_b = {8'(m_bl), 4'(m_pulses), 4'(m_done), 4'(m_tout)};
                checks++;
                if (exp_busy_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy: unexpected busy window len=%0d", m_bl);
                end else begin
                    exp_b = exp_busy_q.pop_front();
                    if (act_b !== exp_b) begin
                        errors++;
                        $display("FAIL busy: got len=%0d pulses=%0d done=%0d tout=%0d expected len=%0d pulses=%0d done=%0d tout=%0d",
                                 act_b[19:12], act_b[11:8], act_b[7:4], act_b[3:0],
                                 exp_b[19:12], exp_b[11:8], exp_b[7:4], exp_b[3:0]);
                    end
                end
                m_bl = 0; m_pulses = 0; m_done = 0; m_tout = 0;
            end
            prev_ce   = ce_out;
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        ce_req  = 1'b0;
        mode_tx = 1'b0;
        repeat (3) @(posedge clk);
        #2 ce_req = 1'b1;
        @(negedge clk);
        check_now("reset_outputs", {3'b0, ce_out, busy, rx_ready, tx_done, timeout}, 8'h00);
        check_now("reset_state", {6'b0, state_dbg}, 8'h00);
        @(posedge clk);
        #2 ce_req = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (5) cycle(1'b0, 1'b0);
        @(negedge clk);
        check_now("idle_outputs", {3'b0, ce_out, busy, rx_ready, tx_done, timeout}, 8'h00);

        // boundary bursts: TX stretch, RX settle, timeout edge
        run_txn(1'b1, 2);
        run_txn(1'b0, 40);
        run_txn(1'b1, 7);
        run_txn(1'b1, 8);
        run_txn(1'b1, 9);
        run_txn(1'b0, 16);
        run_txn(1'b0, 17);
        run_txn(1'b0, 1);
        run_txn(1'b1, MAX_TX - 1);
        run_txn(1'b1, MAX_TX);
        run_txn(1'b1, MAX_TX + 1);
        run_txn(1'b1, 100);

        // back-to-back: request re-raised during GAP and held through gap end
        exp_pulse_q.push_back({8'd10, 8'd0, 8'd0});
        exp_pulse_q.push_back({8'((12 + 10) - (10 + GAP)), 8'd0, 8'd0});
        exp_busy_q.push_back({8'(22 + GAP), 4'd2, 4'd0, 4'd0});
        repeat (10) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b0);
        repeat (16) cycle(1'b0, 1'b0);

        // reset in the middle of a TX burst at cnt=5
        cycle(1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1 check_now("pre_reset_ce", {7'b0, ce_out}, 8'h01);
        #1 reset_n = 1'b0;
        #1 check_now("midburst_reset", {3'b0, ce_out, busy, rx_ready, tx_done, timeout}, 8'h00);
        push_model(1'b1, 3);
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1 check_now("release_ce_low", {7'b0, ce_out}, 8'h00);
        cycle(1'b1, 1'b0);
        #2 check_now("release_ce_high", {7'b0, ce_out}, 8'h01);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (18) cycle(1'b0, 1'b0);

        // randomized bursts with mode_tx toggling while busy
        for (int n = 0; n < 30; n++) run_txn(1'($urandom_range(0, 1)), $urandom_range(1, 45));

        for (int w = 0; w < 300 && (exp_pulse_q.size() != 0 || exp_busy_q.size() != 0); w++)
            @(negedge clk);
        checks++;
        if (exp_pulse_q.size() != 0 || exp_busy_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending pulses=%0d busy=%0d expected 0",
                     exp_pulse_q.size(), exp_busy_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
